// File: rtl/fp_addsub_unit_if.sv
// Issue and CDB signals between the add reservation station,
// the FP add/sub unit and the CDB arbiter.
interface fp_addsub_unit_if #(
  parameter int TAG_W = 4
);
  logic             issue_valid;
  logic             issue_ready;
  logic             issue_op;
  logic [TAG_W-1:0] issue_tag;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_result;
  logic             cdb_grant;

  modport master (
    output issue_valid, issue_op, issue_tag,
    output issue_a, issue_b, cdb_grant,
    input  issue_ready, cdb_valid, cdb_tag,
    input  cdb_result
  );

  modport slave (
    input  issue_valid, issue_op, issue_tag,
    input  issue_a, issue_b, cdb_grant,
    output issue_ready, cdb_valid, cdb_tag,
    output cdb_result
  );
endinterface

// File: rtl/fp_addsub_unit.sv
// Multi-cycle single-precision add/sub unit for the FP-add path.
// Serial alignment and normalization, truncating, CDB broadcast.
module fp_addsub_unit #(
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_addsub_unit_if.slave io
);

  typedef enum logic [2:0] {
    IDLE, ALIGN, ADD, NORM, BCAST
  } state_t;

  state_t           state_q;
  logic             ready_q;
  logic             valid_q;
  logic [TAG_W-1:0] tag_q;
  logic [TAG_W-1:0] ctag_q;
  logic [31:0]      res_q;
  logic             sa_q;
  logic             sb_q;
  logic [7:0]       exp_q;
  logic [23:0]      ma_q;
  logic [23:0]      mb_q;
  logic [4:0]       cnt_q;

  logic        sb_in;
  logic        swap;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [7:0]  ediff;
  logic [4:0]  cnt_d;
  logic [23:0] ma_d;
  logic [23:0] mb_d;
  logic [24:0] sum;
  logic [23:0] dif;

  always_comb begin
    sb_in = io.issue_b[31] ^ io.issue_op;
    swap  = io.issue_b[30:0] > io.issue_a[30:0];
    opa   = swap ? {sb_in, io.issue_b[30:0]}
                 : io.issue_a;
    opb   = swap ? io.issue_a
                 : {sb_in, io.issue_b[30:0]};
    ediff = opa[30:23] - opb[30:23];
    cnt_d = (ediff > 8'd24) ? 5'd24 : ediff[4:0];
    ma_d  = (opa[30:23] != 8'd0)
          ? {1'b1, opa[22:0]} : 24'd0;
    mb_d  = (opb[30:23] != 8'd0)
          ? {1'b1, opb[22:0]} : 24'd0;
    sum   = {1'b0, ma_q} + {1'b0, mb_q};
    dif   = ma_q - mb_q;
  end

  // Zero mantissa always collapses to +0.
  function automatic logic [31:0] pack(
    input logic        s,
    input logic [7:0]  e,
    input logic [23:0] m
  );
    return (m == 24'd0) ? 32'd0 : {s, e, m[22:0]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      tag_q   <= '0;
      ctag_q  <= '0;
      res_q   <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      exp_q   <= 8'd0;
      ma_q    <= 24'd0;
      mb_q    <= 24'd0;
      cnt_q   <= 5'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.issue_valid) begin
            tag_q   <= io.issue_tag;
            sa_q    <= opa[31];
            sb_q    <= opb[31];
            exp_q   <= opa[30:23];
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            ready_q <= 1'b0;
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          if (cnt_q == 5'd0) begin
            state_q <= ADD;
          end else begin
            mb_q  <= mb_q >> 1;
            cnt_q <= cnt_q - 5'd1;
          end
        end
        ADD: begin
          if (sa_q == sb_q) begin
            state_q <= BCAST;
            valid_q <= 1'b1;
            ctag_q  <= tag_q;
            if (!sum[24])
              res_q <= pack(sa_q, exp_q, sum[23:0]);
            else if (exp_q == 8'd254)
              res_q <= {sa_q, 8'hFF, 23'd0};
            else
              res_q <= pack(sa_q, exp_q + 8'd1,
                            sum[24:1]);
          end else if (dif == 24'd0) begin
            state_q <= BCAST;
            valid_q <= 1'b1;
            ctag_q  <= tag_q;
            res_q   <= 32'd0;
          end else begin
            ma_q    <= dif;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (ma_q[23]) begin
            state_q <= BCAST;
            valid_q <= 1'b1;
            ctag_q  <= tag_q;
            res_q   <= pack(sa_q, exp_q, ma_q);
          end else if (exp_q == 8'd1) begin
            state_q <= BCAST;
            valid_q <= 1'b1;
            ctag_q  <= tag_q;
            res_q   <= 32'd0;
          end else begin
            ma_q  <= ma_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        BCAST: begin
          if (io.cdb_grant) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.issue_ready = ready_q;
  assign io.cdb_valid   = valid_q;
  assign io.cdb_tag     = ctag_q;
  assign io.cdb_result  = res_q;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Scoreboard bench for fp_addsub_unit: directed vectors,
// latency, backpressure and mid-operation reset.
module tb_fp_addsub_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   ncmp;
  int   nfail;
  bit   hold;

  fp_addsub_unit_if #(.TAG_W(4)) io ();

  fp_addsub_unit #(.TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have;
  bit   prev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    io.cdb_grant = io.cdb_valid && !hold;
  end

  always @(negedge clk) begin
    if (rst) begin
      have = 1'b0;
    end else if (io.cdb_valid) begin
      if (!prev) begin
        if (q.size() == 0) begin
          ncmp++;
          nfail++;
          have = 1'b0;
          $display("FAIL unexpected_bcast: got tag=%0d res=%h want none",
                   io.cdb_tag, io.cdb_result);
        end else begin
          cur  = q.pop_front();
          have = 1'b1;
          chk("cdb_tag", 32'(io.cdb_tag), 32'(cur.tag));
          chk("cdb_result", io.cdb_result, cur.res);
          chk("latency", 32'(cyc - cur.acc),
              32'(cur.lat));
        end
      end else if (have) begin
        chk("hold_tag", 32'(io.cdb_tag), 32'(cur.tag));
        chk("hold_result", io.cdb_result, cur.res);
      end
    end
    prev = io.cdb_valid;
  end

  task automatic do_issue(input logic op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [3:0] tag,
                          input logic [31:0] res,
                          input int lat,
                          input bit expect_rsp,
                          output int acc);
    int n;
    n = 0;
    while (!io.issue_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      ncmp++;
      nfail++;
      $display("FAIL issue_timeout: got ready=0 want 1");
    end
    io.issue_valid = 1'b1;
    io.issue_op    = op;
    io.issue_a     = a;
    io.issue_b     = b;
    io.issue_tag   = tag;
    @(posedge clk);
    #1;
    acc = cyc;
    if (expect_rsp)
      q.push_back('{tag: tag, res: res,
                    lat: lat, acc: acc});
    io.issue_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || io.cdb_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      ncmp++;
      nfail++;
      $display("FAIL done_timeout: got pending=%0d want 0",
               q.size());
    end
  endtask

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int acc;
    int gcyc;
    int n;
    ncmp  = 0;
    nfail = 0;
    cyc   = 0;
    hold  = 1'b0;
    have  = 1'b0;
    prev  = 1'b0;
    rst   = 1'b1;
    io.issue_valid = 1'b0;
    io.issue_op    = 1'b0;
    io.issue_a     = 32'd0;
    io.issue_b     = 32'd0;
    io.issue_tag   = 4'd0;
    io.cdb_grant   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(io.issue_ready), 32'd1);
    chk("rst_valid", 32'(io.cdb_valid), 32'd0);
    chk("rst_tag", 32'(io.cdb_tag), 32'd0);
    chk("rst_result", io.cdb_result, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs = '{
      '{0, 32'h3F800000, 32'h3F800000, 4'd3, 32'h40000000, 2},
      '{0, 32'h40400000, 32'h3F800000, 4'd1, 32'h40800000, 3},
      '{1, 32'h3FC00000, 32'h3F800000, 4'd2, 32'h3F000000, 4},
      '{1, 32'h40400000, 32'h40400000, 4'd4, 32'h00000000, 2},
      '{0, 32'h4C000000, 32'h3F800000, 4'd6, 32'h4C000000, 26},
      '{0, 32'hBF800000, 32'h40000000, 4'd7, 32'h3F800000, 5},
      '{0, 32'h00000000, 32'h00000000, 4'd8, 32'h00000000, 2},
      '{1, 32'h3F800000, 32'hBF800000, 4'd9, 32'h40000000, 2},
      '{0, 32'h7F000000, 32'h7F000000, 4'd5, 32'h7F800000, 2},
      '{1, 32'h00C00000, 32'h00800000, 4'd10, 32'h00000000, 3}
    };
    foreach (vecs[i]) begin
      do_issue(vecs[i].op, vecs[i].a, vecs[i].b,
               vecs[i].tag, vecs[i].res, vecs[i].lat,
               1'b1, acc);
      wait_done();
    end

    // Hold the CDB for 5 cycles; stray issues must be ignored.
    hold = 1'b1;
    do_issue(0, 32'h3F800000, 32'h3F800000, 4'd5,
             32'h40000000, 2, 1'b1, acc);
    n = 0;
    while (!io.cdb_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_up", 32'(io.cdb_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(io.issue_ready), 32'd0);
      chk("bp_valid_held", 32'(io.cdb_valid), 32'd1);
      io.issue_valid = k[0];
      io.issue_tag   = 4'd15;
      io.issue_a     = 32'h40000000;
      io.issue_b     = 32'h40000000;
    end
    io.issue_valid = 1'b0;
    hold = 1'b0;
    wait_done();
    gcyc = cyc;
    chk("grant_ready", 32'(io.issue_ready), 32'd1);
    chk("grant_valid", 32'(io.cdb_valid), 32'd0);
    do_issue(0, 32'h40400000, 32'h3F800000, 4'd11,
             32'h40800000, 3, 1'b1, acc);
    chk("b2b_accept", 32'(acc - gcyc), 32'd1);
    wait_done();

    do_issue(0, 32'h4B000000, 32'h3F800000, 4'd12,
             32'h0, 0, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(io.cdb_valid), 32'd0);
    chk("midrst_ready", 32'(io.issue_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_nobcast", 32'(io.cdb_valid), 32'd0);

    do_issue(0, 32'h3F800000, 32'h3F800000, 4'd13,
             32'h40000000, 2, 1'b1, acc);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fp_addsub_unit.md
Name: fp_addsub_unit

Overview:
- Multi-cycle single-precision FP add/subtract functional unit for the Tomasulo FP-add path.
- It is the responder end of the issue interface: it accepts one operation at a time from the add reservation station over a valid/ready handshake.
- It aligns the smaller operand one bit per cycle, adds, then normalizes one bit per cycle.
- It broadcasts the tagged result on the CDB and holds it until granted.

Parameters:
TAG_W, 4, width of reservation-station tag carried with the operation

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
issue_valid  input  1  reservation station presents an operation
issue_ready  output  1  unit can accept (high only in IDLE)
issue_op  input  1  0 = a+b, 1 = a-b
issue_tag  input  TAG_W  tag of issuing station
issue_a  input  32  IEEE-754 single operand a
issue_b  input  32  IEEE-754 single operand b
cdb_valid  output  1  result present on CDB
cdb_tag  output  TAG_W  tag of result
cdb_result  output  32  IEEE-754 single result
cdb_grant  input  1  CDB arbiter accepts result this cycle

Behaviour:
- Reset (async, immediate):
  - state=IDLE, issue_ready=1, cdb_valid=0, cdb_tag=0, cdb_result=0.
  - Reset mid-operation discards the operation; no partial broadcast.
- States: IDLE, ALIGN, ADD, NORM, BCAST.
- IDLE → ALIGN on the rising edge where issue_valid && issue_ready. This is the accept edge. On that edge:
  - Latch the tag.
  - Form b' = b with sign inverted if issue_op=1.
  - Swap so that |A| >= |B|, comparing bits [30:0]; A=a on tie.
  - Hidden bit = 1 if exponent != 0, else 0. Exponent-0 operands are treated as zero; no denormal/NaN/Inf handling.
  - cnt = min(eA−eB, 24).
  - Result sign = sign of A; result exponent = eA.
- issue_valid is ignored outside IDLE.
- ALIGN, each cycle:
  - If cnt==0 → ADD.
  - Else mB >>= 1 (truncate, no guard/round bits), cnt−1.
- ADD, one cycle:
  - Same signs: 25-bit sum.
    - On carry: m = sum>>1 (truncate), exp+1. If exp becomes 255, result = sign,0xFF,0 (Inf).
    - → BCAST.
  - Different signs: m = mA−mB (never negative).
    - If m==0 → BCAST with result 32'h00000000.
    - Else → NORM.
- NORM, each cycle:
  - If m[23]==1 → BCAST.
  - Else if exp==1 → flush: result 32'h00000000, → BCAST.
  - Else m <<= 1, exp−1.
- Any zero final mantissa is forced to 32'h00000000 (positive zero).
- BCAST:
  - cdb_valid=1; cdb_tag and cdb_result are registered and stable until grant.
  - On an edge with cdb_grant=1 → IDLE; cdb_valid falls, issue_ready rises the same edge.
  - New issue is accepted no earlier than the edge after the grant.
  - cdb_grant outside BCAST is ignored.
- Latency (accept edge → edge raising cdb_valid), with D' = min(D,24) and N = normalization shifts:
  - 2 + D' with no NORM.
  - 3 + D' + N when NORM is entered.
- Rounding: truncation only.

Test Plan:
- Add 3F800000 + 3F800000, tag 3 → cdb_result 40000000, cdb_tag 3, cdb_valid 2 cycles after accept.
- Add 40400000 + 3F800000 → 40800000 (carry path, exp 129), latency 3. Sub 3FC00000 − 3F800000 → 3F000000, N=1, latency 4.
- Cancellation and clamp cases:
  - Sub 40400000 − 40400000 → 00000000, latency 2.
  - Add 4C000000 + 3F800000 (D=25, clamped to 24) → 4C000000, latency 26.
- Backpressure:
  - Hold cdb_grant=0 for 5 cycles in BCAST → cdb_valid, tag and result stable; issue_ready=0; issue_valid pulses ignored.
  - Grant → IDLE next edge; a back-to-back issue is accepted on the following edge.
- Reset mid-op: add 4B000000 + 3F800000 (D=23), assert rst during ALIGN → cdb_valid=0 and issue_ready=1 immediately; no broadcast after release.
- Operand order and sign:
  - Add BF800000 + 40000000 → 3F800000 (sign from larger magnitude).
  - Add 00000000 + 00000000 → 00000000.
  - Sub 3F800000 − BF800000 → 40000000.
